// File: rtl/fpu_addsub_sched_pkg.sv
// Shared types and defaults for the FPU add/sub scheduler.
//   OP_ADD / OP_SUB : datapath operation bit encoding
//   req_id_t        : requester index (1 bit, two requesters)
//   tag_t           : in-flight ownership tag {valid, id}
//   DEF_LAT / DEF_RESP_DEPTH : default datapath latency and response FIFO depth
package fpu_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEF_LAT        = 4;
  localparam int unsigned DEF_RESP_DEPTH = 2;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fpu_addsub_sched_if.sv
// Bundle of the scheduler's request, response and datapath-side signals.
//   slave  : seen from the scheduler (accepts requests, drives responses and the datapath issue)
//   master : seen from the environment (requesters, consumers and the datapath model)
interface fpu_addsub_sched_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_op;

  logic        resp0_valid;
  logic        resp0_ready;
  logic [31:0] resp0_data;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp1_data;

  logic        dp_valid;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_op;
  logic [31:0] dp_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data, resp1_valid, resp1_data,
    input  resp0_ready, resp1_ready,
    output dp_valid, dp_a, dp_b, dp_op,
    input  dp_result
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data, resp1_valid, resp1_data,
    output resp0_ready, resp1_ready,
    input  dp_valid, dp_a, dp_b, dp_op,
    output dp_result
  );

endinterface

// File: rtl/fpu_resp_fifo.sv
// First-word-fall-through 32-bit response FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data this cycle (caller guarantees a free slot, pop-same-cycle included)
//   i_pop      : consumer takes the head; ignored when empty
//   o_data     : current head, forced to 0 while empty
//   o_empty    : no entries stored
module fpu_resp_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic [31:0] o_data,
  output logic        o_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [31:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            w_pop;

  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? 32'd0 : r_mem[r_rptr];

  // A push while full is only legal together with a pop; the slot written is the one
  // being vacated, and the head is read combinationally before the edge.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + PtrW'(1);
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!i_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Shares one fixed-latency FP add/sub datapath between two requesters.
// Round-robin arbitration (fixed priority to requester 0 when FPU_SCHED_FIXED_PRIO_EN is
// defined), one issue per cycle, a LAT-deep ownership tag pipe, and a FWFT response FIFO per
// requester. Per-requester credits bound outstanding ops to the FIFO depth.
//   clk, rst_n : clock, asynchronous active-low reset
//   sched_if   : request ports, response ports and datapath issue/result (slave modport)
module fpu_addsub_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned LAT        = DEF_LAT,
  parameter int unsigned RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  fpu_addsub_sched_if.slave  sched_if
);

  localparam int unsigned CredW = $clog2(RESP_DEPTH + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(RESP_DEPTH);

  logic [CredW-1:0] r_credit0;
  logic [CredW-1:0] r_credit1;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_pop0;
  logic             w_pop1;
  logic             w_push0;
  logic             w_push1;
  logic             w_empty0;
  logic             w_empty1;

  logic             r_dp_valid;
  logic [31:0]      r_dp_a;
  logic [31:0]      r_dp_b;
  logic             r_dp_op;
  req_id_t          r_dp_id;
  tag_t             r_tag [LAT];
  tag_t             w_tag_out;

  assign w_elig0 = sched_if.req0_valid && (r_credit0 < CredMax);
  assign w_elig1 = sched_if.req1_valid && (r_credit1 < CredMax);

`ifdef FPU_SCHED_FIXED_PRIO_EN
  always_comb begin
    w_grant0 = w_elig0;
    w_grant1 = w_elig1 && !w_elig0;
  end
`else
  req_id_t r_last_grant;

  // On a tie the requester not granted last wins.
  always_comb begin
    w_grant0 = w_elig0 && (!w_elig1 || (r_last_grant == 1'b1));
    w_grant1 = w_elig1 && (!w_elig0 || (r_last_grant == 1'b0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_acc0) begin
      r_last_grant <= 1'b0;
    end else if (w_acc1) begin
      r_last_grant <= 1'b1;
    end
  end
`endif

  // Readies are held low while reset is asserted even though credits already read zero.
  assign w_acc0 = w_grant0 && rst_n;
  assign w_acc1 = w_grant1 && rst_n;
  assign sched_if.req0_ready = w_acc0;
  assign sched_if.req1_ready = w_acc1;

  assign w_pop0 = sched_if.resp0_valid && sched_if.resp0_ready;
  assign w_pop1 = sched_if.resp1_valid && sched_if.resp1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit0 <= '0;
      r_credit1 <= '0;
    end else begin
      if (w_acc0 && !w_pop0) begin
        r_credit0 <= r_credit0 + CredW'(1);
      end else if (!w_acc0 && w_pop0) begin
        r_credit0 <= r_credit0 - CredW'(1);
      end
      if (w_acc1 && !w_pop1) begin
        r_credit1 <= r_credit1 + CredW'(1);
      end else if (!w_acc1 && w_pop1) begin
        r_credit1 <= r_credit1 - CredW'(1);
      end
    end
  end

  // Issue register: data outputs hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_valid <= 1'b0;
      r_dp_a     <= '0;
      r_dp_b     <= '0;
      r_dp_op    <= OP_ADD;
      r_dp_id    <= '0;
    end else begin
      r_dp_valid <= w_acc0 || w_acc1;
      if (w_acc0 || w_acc1) begin
        r_dp_a  <= w_acc1 ? sched_if.req1_a  : sched_if.req0_a;
        r_dp_b  <= w_acc1 ? sched_if.req1_b  : sched_if.req0_b;
        r_dp_op <= w_acc1 ? sched_if.req1_op : sched_if.req0_op;
        r_dp_id <= w_acc1;
      end
    end
  end

  assign sched_if.dp_valid = r_dp_valid;
  assign sched_if.dp_a     = r_dp_a;
  assign sched_if.dp_b     = r_dp_b;
  assign sched_if.dp_op    = r_dp_op;

  // Fed from the issue register, so the last stage is valid exactly LAT cycles after dp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: r_dp_valid, id: r_dp_id};
      for (int unsigned i = 1; i < LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_tag_out = r_tag[LAT-1];
  assign w_push0   = w_tag_out.valid && (w_tag_out.id == 1'b0);
  assign w_push1   = w_tag_out.valid && (w_tag_out.id == 1'b1);

  fpu_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_data  (sched_if.dp_result),
    .i_pop   (sched_if.resp0_ready),
    .o_data  (sched_if.resp0_data),
    .o_empty (w_empty0)
  );

  fpu_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_data  (sched_if.dp_result),
    .i_pop   (sched_if.resp1_ready),
    .o_data  (sched_if.resp1_data),
    .o_empty (w_empty1)
  );

  assign sched_if.resp0_valid = !w_empty0;
  assign sched_if.resp1_valid = !w_empty1;

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Self-checking bench for fpu_addsub_sched: table-driven single ops, tie arbitration,
// credit stall, simultaneous accept/pop, mid-flight reset. A behavioural datapath returns
// FP results LAT cycles after dp_valid and garbage otherwise.
module tb_fpu_addsub_sched;
  import fpu_sched_pkg::*;

  localparam int unsigned LAT        = DEF_LAT;
  localparam int unsigned RESP_DEPTH = DEF_RESP_DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_addsub_sched_if bus ();

  fpu_addsub_sched #(
    .LAT        (LAT),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_if (bus)
  );

  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    real ra, rb;
    ra = sp2real(a);
    rb = sp2real(b);
    return real2sp((op == OP_SUB) ? ra - rb : ra + rb);
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  // Behavioural datapath; untagged slots carry random data so stale pushes would show.
  logic [31:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= bus.dp_valid ? fp_model(bus.dp_a, bus.dp_b, bus.dp_op) : $urandom();
    for (int i = 1; i < int'(LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dp_result = dp_pipe[LAT-1];

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          grant_log [$];
  int          m_cred0, m_cred1, m_last;
  logic        prev_acc;
  logic [31:0] prev_a, prev_b;
  logic        prev_op;
  logic        s_resp0_valid, s_resp1_valid;
  logic [31:0] s_data0, s_data1;
  int          acc_cnt0 = 0;
  int          acc_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q0.delete();
    exp_q1.delete();
    m_cred0  = 0;
    m_cred1  = 0;
    m_last   = 1;
    prev_acc = 1'b0;
  endtask

  // Samples between edges: grant prediction, issue check, scoreboard push/pop.
  task automatic monitor();
    logic e0, e1, g0, g1, a0, a1, p0, p1;
    e0 = bus.req0_valid && (m_cred0 < int'(RESP_DEPTH));
    e1 = bus.req1_valid && (m_cred1 < int'(RESP_DEPTH));
`ifdef FPU_SCHED_FIXED_PRIO_EN
    g0 = e0;
    g1 = e1 && !e0;
`else
    g0 = e0 && (!e1 || m_last == 1);
    g1 = e1 && (!e0 || m_last == 0);
`endif
    chk("grant", 32'({bus.req1_ready, bus.req0_ready}), 32'({g1, g0}));
    chk("dp_valid", 32'(bus.dp_valid), 32'(prev_acc));
    if (prev_acc) begin
      chk("dp_a", bus.dp_a, prev_a);
      chk("dp_b", bus.dp_b, prev_b);
      chk("dp_op", 32'(bus.dp_op), 32'(prev_op));
    end
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    p0 = bus.resp0_valid && bus.resp0_ready;
    p1 = bus.resp1_valid && bus.resp1_ready;
    s_resp0_valid = bus.resp0_valid;
    s_resp1_valid = bus.resp1_valid;
    s_data0 = bus.resp0_data;
    s_data1 = bus.resp1_data;
    if (p0) begin
      if (exp_q0.size() == 0) chk("resp0_unexpected", 32'(1), 32'(0));
      else chk("resp0_data", bus.resp0_data, exp_q0.pop_front());
      m_cred0--;
    end
    if (p1) begin
      if (exp_q1.size() == 0) chk("resp1_unexpected", 32'(1), 32'(0));
      else chk("resp1_data", bus.resp1_data, exp_q1.pop_front());
      m_cred1--;
    end
    prev_acc = a0 || a1;
    if (a0) begin
      exp_q0.push_back(fp_model(bus.req0_a, bus.req0_b, bus.req0_op));
      grant_log.push_back(0);
      acc_cnt0++;
      m_cred0++;
      m_last = 0;
      prev_a = bus.req0_a; prev_b = bus.req0_b; prev_op = bus.req0_op;
    end else if (a1) begin
      exp_q1.push_back(fp_model(bus.req1_a, bus.req1_b, bus.req1_op));
      grant_log.push_back(1);
      acc_cnt1++;
      m_cred1++;
      m_last = 1;
      prev_a = bus.req1_a; prev_b = bus.req1_b; prev_op = bus.req1_op;
    end
  endtask

  task automatic tick();
    #2;
    monitor();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = OP_ADD;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = OP_ADD;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
  endtask

  task automatic drain(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  task automatic rand_ops();
    bus.req0_a = rand_fp(); bus.req0_b = rand_fp(); bus.req0_op = 1'($urandom);
    bus.req1_a = rand_fp(); bus.req1_b = rand_fp(); bus.req1_op = 1'($urandom);
  endtask

  task automatic check_zero_outputs(input string tagname);
    chk({tagname, "_req0_ready"}, 32'(bus.req0_ready), 32'(0));
    chk({tagname, "_req1_ready"}, 32'(bus.req1_ready), 32'(0));
    chk({tagname, "_dp_valid"}, 32'(bus.dp_valid), 32'(0));
    chk({tagname, "_dp_a"}, bus.dp_a, 32'(0));
    chk({tagname, "_dp_b"}, bus.dp_b, 32'(0));
    chk({tagname, "_dp_op"}, 32'(bus.dp_op), 32'(0));
    chk({tagname, "_resp0_valid"}, 32'(bus.resp0_valid), 32'(0));
    chk({tagname, "_resp1_valid"}, 32'(bus.resp1_valid), 32'(0));
    chk({tagname, "_resp0_data"}, bus.resp0_data, 32'(0));
    chk({tagname, "_resp1_data"}, bus.resp1_data, 32'(0));
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lat, n_stale;
    logic found;

    vecs[0] = '{1'b0, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000};
    vecs[1] = '{1'b1, 32'h4040_0000, 32'h3F80_0000, OP_SUB, 32'h4000_0000};
    vecs[2] = '{1'b0, 32'h3FC0_0000, 32'h3F00_0000, OP_ADD, 32'h4000_0000};
    vecs[3] = '{1'b1, 32'h4000_0000, 32'h4000_0000, OP_SUB, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h3F80_0000, 32'h4040_0000, OP_SUB, 32'hC000_0000};
    vecs[5] = '{1'b1, 32'hBF80_0000, 32'hBF80_0000, OP_ADD, 32'hC000_0000};

    // Reset with both requests pending: readies must stay low.
    set_idle();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_clear();
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();

    // Single ops from the table, one at a time, with exact latency.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (vecs[i].id) begin
        bus.req1_valid = 1'b1; bus.req1_a = vecs[i].a; bus.req1_b = vecs[i].b;
        bus.req1_op = vecs[i].op;
      end else begin
        bus.req0_valid = 1'b1; bus.req0_a = vecs[i].a; bus.req0_b = vecs[i].b;
        bus.req0_op = vecs[i].op;
      end
      base = acc_cnt0 + acc_cnt1;
      tick();
      chk("vec_accept", 32'(acc_cnt0 + acc_cnt1 - base), 32'(1));
      set_idle();
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        tick();
        if (vecs[i].id ? s_resp1_valid : s_resp0_valid) begin
          lat = n;
          break;
        end
      end
      chk("vec_latency", 32'(lat), 32'(LAT + 2));
      chk("vec_data", vecs[i].id ? s_data1 : s_data0, vecs[i].res);
    end

    drain(12);

    // Tie: both requesters valid every cycle.
    grant_log.delete();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
`ifdef FPU_SCHED_FIXED_PRIO_EN
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      tick();
    end
    chk("fixed_grant_count", 32'(grant_log.size()), 32'(2 * RESP_DEPTH));
    for (int i = 0; i < grant_log.size(); i++) begin
      chk("fixed_grant_order", 32'(grant_log[i]), (i < int'(RESP_DEPTH)) ? 32'(0) : 32'(1));
    end
`else
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      tick();
    end
    chk("tie_first_grant", 32'(grant_log[0]), 32'(0));
    for (int i = 1; i < grant_log.size(); i++) begin
      chk("tie_alternate", 32'(grant_log[i]), 32'(1 - grant_log[i-1]));
    end
`endif
    drain(15);

    // Credit stall on requester 1 while its consumer is blocked.
    base = acc_cnt1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.resp1_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      tick();
    end
    chk("stall_accepts", 32'(acc_cnt1 - base), 32'(RESP_DEPTH));
    bus.req0_valid = 1'b0;
    tick();
    chk("stall_held", 32'(acc_cnt1 - base), 32'(RESP_DEPTH));
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      tick();
    end
    chk("stall_reopen", 32'(acc_cnt1 - base > int'(RESP_DEPTH)), 32'(1));
    drain(15);

    // Accept and pop in the same cycle at credit RESP_DEPTH-1.
    bus.req1_valid = 1'b1;
    bus.resp1_ready = 1'b0;
    rand_ops();
    tick();
    bus.req1_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (s_resp1_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("simul_resp_seen", 32'(found), 32'(1));
    base = acc_cnt1;
    bus.req1_valid = 1'b1;
    bus.resp1_ready = 1'b1;
    rand_ops();
    tick();
    chk("simul_accept", 32'(acc_cnt1 - base), 32'(1));
    base = acc_cnt1;
    bus.resp1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      tick();
    end
    chk("simul_credit_kept", 32'(acc_cnt1 - base), 32'(RESP_DEPTH - 1));
    drain(15);
    chk("simul_drained", 32'(exp_q1.size()), 32'(0));

    // Reset with three operations in flight.
    base = acc_cnt0 + acc_cnt1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      tick();
    end
    chk("midflight_accepts", 32'(acc_cnt0 + acc_cnt1 - base), 32'(3));
    set_idle();
    tick();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    n_stale = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_resp0_valid || s_resp1_valid) n_stale++;
    end
    chk("midrst_no_stale", 32'(n_stale), 32'(0));

    drain(5);
    chk("final_q0_empty", 32'(exp_q0.size()), 32'(0));
    chk("final_q1_empty", 32'(exp_q1.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
